// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first.
// The serial line is synchronised, the start bit is qualified at its midpoint,
// and every following bit is sampled one bit period later, close to its centre.
// A low stop bit raises a frame error and parks the receiver until the line
// returns high, so a held-low (break) line produces no further strobes.
module uart_rx #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115_200
) (
   input  logic       CLK,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       err_frame,
   output logic       busy
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLKS_PER_BIT - 1);

   // Fewer than four clocks per bit leaves no room to find the bit centre.
   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_ratio
         $error("uart_rx: CLK_HZ/BAUD must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   // registers
   logic             r_sync1;
   logic             r_sync2;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bidx;
   logic [7:0]       r_shift;
   logic [7:0]       r_data;
   logic             r_valid;
   logic             r_err;
   logic             r_busy;

   // combinational next values
   logic             w_rx_s;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       w_bidx_nxt;
   logic [7:0]       w_shift_nxt;
   logic             w_load;
   logic             w_valid_nxt;
   logic             w_err_nxt;

   assign w_rx_s    = r_sync2;
   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign err_frame = r_err;
   assign busy      = r_busy;

   // Two-flop synchroniser for the asynchronous line; idles high out of reset.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   // Next-state, counter, bit index and strobe decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_ONE;
      w_bidx_nxt  = r_bidx;
      w_shift_nxt = r_shift;
      w_load      = 1'b0;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = CNT_ZERO;
            if (!w_rx_s) begin
               w_state_nxt = S_START;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end

         S_START: begin
            if (r_cnt == CNT_MID) begin
               w_cnt_nxt = CNT_ZERO;
               if (!w_rx_s) begin
                  w_state_nxt = S_DATA;
                  w_bidx_nxt  = 3'd0;
               end else begin
                  // line went back high before mid start bit: a glitch
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_state_nxt = S_START;
            end
         end

         S_DATA: begin
            if (r_cnt == CNT_END) begin
               w_cnt_nxt           = CNT_ZERO;
               w_shift_nxt[r_bidx] = w_rx_s;
               w_bidx_nxt          = r_bidx + 3'd1;
               if (r_bidx == 3'd7) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_state_nxt = S_DATA;
               end
            end else begin
               w_state_nxt = S_DATA;
            end
         end

         S_STOP: begin
            if (r_cnt == CNT_END) begin
               // mid stop bit: leave now so a following start edge is caught
               w_cnt_nxt = CNT_ZERO;
               if (w_rx_s) begin
                  w_load      = 1'b1;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end else begin
               w_state_nxt = S_STOP;
            end
         end

         S_BREAK: begin
            w_cnt_nxt = CNT_ZERO;
            if (w_rx_s) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_BREAK;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = CNT_ZERO;
            w_bidx_nxt  = 3'd0;
         end
      endcase
   end

   // State register and busy flag, which mirrors "state is not idle".
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   // Bit timing counter, bit index and shift register.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= CNT_ZERO;
         r_bidx  <= 3'd0;
         r_shift <= 8'h00;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_bidx  <= w_bidx_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   // Registered output byte and one-cycle strobes.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= 8'h00;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_load) begin
            r_data <= r_shift;
         end
         r_valid <= w_valid_nxt;
         r_err   <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
// Frames are driven on a time base independent of the clock; expected strobes
// go into a queue when a frame is driven and are matched as the DUT emits them.
module tb_uart_rx;

   localparam int T_BIT = 1600;          // 16 clocks of 100 time units
   localparam int T_SLOW = 1648;         // transmitter 3% slow
   localparam int T_FAST = 1552;         // transmitter 3% fast

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       err_frame;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_valid_cyc = 0;

   typedef struct {
      logic       is_err;
      logic [7:0] data;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [7:0] data;
      int         bit_t;
      int         gap;
      bit         chk_lat;
      bit         idle_after;
   } vec_t;
   vec_t vecs[9];

   uart_rx #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
      .CLK      (clk),
      .rst_n    (rst_n),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .err_frame(err_frame),
      .busy     (busy)
   );

   always #50 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      n_checks++;
      if (got < lo || got > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   // Drive one 8N1 frame; the line is left at the stop-bit level.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int bt);
      rx = 1'b0;
      #(bt);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #(bt);
      end
      rx = stop;
      #(bt);
   endtask

   // Scoreboard: every strobe must match the oldest expected event.
   always @(negedge clk) begin
      if (rst_n && (rx_valid || err_frame)) begin
         check("strobe_exclusive", {31'd0, rx_valid & err_frame}, 32'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got valid=%0b err=%0b data=%0h expected none",
                     rx_valid, err_frame, rx_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("strobe_kind_is_err", {31'd0, err_frame}, {31'd0, e.is_err});
            check("strobe_rx_data", {24'd0, rx_data}, {24'd0, e.data});
         end
         if (rx_valid) last_valid_cyc = cyc;
      end
   end

   initial begin
      int start_cyc;
      int n;

      vecs[0] = '{8'hAA, T_BIT,  4, 1'b1, 1'b1};
      vecs[1] = '{8'hAA, T_BIT,  4, 1'b0, 1'b0};
      vecs[2] = '{8'h04, T_BIT,  0, 1'b0, 1'b0};
      vecs[3] = '{8'h01, T_BIT,  0, 1'b0, 1'b0};
      vecs[4] = '{8'h02, T_BIT,  0, 1'b0, 1'b0};
      vecs[5] = '{8'h3C, T_BIT,  0, 1'b0, 1'b0};
      vecs[6] = '{8'h5A, T_BIT,  0, 1'b0, 1'b1};
      vecs[7] = '{8'hC3, T_FAST, 4, 1'b0, 1'b1};
      vecs[8] = '{8'hC3, T_SLOW, 4, 1'b0, 1'b1};

      // reset state
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_err_frame", {31'd0, err_frame}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // table: single frame, back-to-back burst, skewed baud
      start_cyc = 0;
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].gap > 0) begin
            repeat (vecs[i].gap) @(negedge clk);
            #3;
         end
         start_cyc = cyc;
         exp_q.push_back('{1'b0, vecs[i].data});
         send_frame(vecs[i].data, 1'b1, vecs[i].bit_t);
         if (vecs[i].idle_after) begin
            repeat (4) @(negedge clk);
            check("busy_after_frame", {31'd0, busy}, 32'd0);
            check("rx_data_after_frame", {24'd0, rx_data}, {24'd0, vecs[i].data});
         end
         if (vecs[i].chk_lat) begin
            check_range("valid_latency", last_valid_cyc - start_cyc, 154, 156);
         end
      end

      // framing error followed by a long break, then a good byte
      repeat (4) @(negedge clk);
      #3;
      exp_q.push_back('{1'b1, 8'hC3});
      send_frame(8'h55, 1'b0, T_BIT);
      #(20 * T_BIT);
      check("busy_in_break", {31'd0, busy}, 32'd1);
      check("rx_data_held_in_break", {24'd0, rx_data}, 32'hC3);
      #(19 * T_BIT);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check("busy_after_break", {31'd0, busy}, 32'd0);
      #3;
      exp_q.push_back('{1'b0, 8'h12});
      send_frame(8'h12, 1'b1, T_BIT);
      repeat (4) @(negedge clk);

      // five-cycle glitch on an idle line
      rx = 1'b0;
      repeat (5) @(negedge clk);
      check("busy_during_glitch", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      n = 0;
      while (busy && n < 12) begin
         @(negedge clk);
         n++;
      end
      check_range("glitch_back_to_idle", n, 0, 10);
      repeat (10) @(negedge clk);

      // reset during bit 4 of 8'hF0, then a clean 8'h0F
      #3;
      fork
         send_frame(8'hF0, 1'b1, T_BIT);
         begin
            repeat (85) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
            check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
            check("midreset_err_frame", {31'd0, err_frame}, 32'd0);
            check("midreset_busy", {31'd0, busy}, 32'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      repeat (6) @(negedge clk);
      check("rx_data_after_reset", {24'd0, rx_data}, 32'd0);
      #3;
      exp_q.push_back('{1'b0, 8'h0F});
      send_frame(8'h0F, 1'b1, T_BIT);

      repeat (40) @(negedge clk);
      check("rx_data_final", {24'd0, rx_data}, 32'h0F);
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
